half_exp2_split: RTL and testbench
==================================

HALF_EXP2_SPLIT -- requirements
Module: half_exp2_split

Interface
REQ-001 SHALL have parameter PRECISION, default "HALF": operand format; only "HALF" is supported, any other value SHALL fail elaboration.
REQ-002 SHALL have port clk, input, 1: sole clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1: the operand on a is valid.
REQ-005 SHALL have port in_ready, output, 1: the block accepts an operand; a transfer occurs when in_valid && in_ready.
REQ-006 SHALL have port a, input, 16: the IEEE half-precision operand x.
REQ-007 SHALL have port out_valid, output, 1: n, f, ovf and nan are valid.
REQ-008 SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-009 SHALL have port n, output, 16: floor(x) as two's-complement; it feeds the integer-power stage.
REQ-010 SHALL have port f, output, 16: x-n as half, with 0 <= f < 1.
REQ-011 SHALL have port ovf, output, 1: n saturated.
REQ-012 SHALL have port nan, output, 1: the operand is NaN.

Function
REQ-013 SHALL be a 3-stage pipeline (S1 unpack/classify, S2 fixed-point split/negate, S3 normalize/pack) with latency 3 cycles from accept to out_valid when not stalled, and throughput 1 per cycle.
REQ-014 SHALL stall all stages when out_valid && !out_ready; in_ready = !(out_valid && !out_ready).
REQ-015 SHALL hold n, f, ovf and nan stable while stalled, and SHALL neither drop, duplicate nor reorder results.
REQ-016 S1 SHALL convert a finite x to exact unsigned magnitude Q16.24 (40 bits): subnormal = mant; normal = {1,mant} << (exp-1).
REQ-017 S2 SHALL split magnitude into I (bits 39:24) and F (bits 23:0).
- Positive x: n=I, Fo=F.
- Negative x, F==0: n=-I, Fo=0.
- Negative x, F!=0: n=-(I+1), Fo=2^24-F.
REQ-018 SHALL saturate n to 0x7FFF or 0x8000 and set ovf when floor(x) is outside [-32768, 32767]; x = -32768 exactly SHALL give n=0x8000 with ovf=0.
REQ-019 S3 SHALL pack Fo to half with f's sign always 0, truncating (never rounding):
- Fo=0 -> f=0x0000.
- Leading one at bit p>=10 -> exp=p-9, mantissa = the 10 bits below p.
- p<10 -> subnormal, mantissa=Fo[9:0].
REQ-020 SHALL map +0 and -0 to n=0, f=0x0000.
REQ-021 SHALL map +Inf to n=0x7FFF, f=0, ovf=1, and -Inf to n=0x8000, f=0, ovf=1.
REQ-022 SHALL map any NaN to n=0, f=0x7E00, nan=1, ovf=0.
REQ-023 SHALL drive ovf=0 and nan=0 for all finite in-range operands.

Reset
REQ-024 While rst=1, SHALL force out_valid=0, in_ready=1, all stage valid bits=0, n=0, f=0, ovf=0, nan=0.
REQ-025 Reset asserted mid-operation SHALL discard in-flight operands; no result for them SHALL appear after rst deasserts.

Structure
REQ-026 SHALL take the half field widths, bias 15, QNAN 0x7E00, NMAX 0x7FFF, NMIN 0x8000 and the Q16.24 width constants from a shared package.
REQ-027 SHALL instantiate one sub-module, lzc24, a combinational leading-zero counter used by S3.

Verification
REQ-028 a=0x3E00 (1.5) -> n=0x0001, f=0x3800, out_valid exactly 3 cycles after accept.
REQ-029 a=0xBE00 (-1.5) -> n=0xFFFE, f=0x3800; a=0xB400 (-0.25) -> n=0xFFFF, f=0x3A00.
REQ-030 a=0x8001 (-2^-24) -> n=0xFFFF, f=0x3BFF (truncated); a=0x0001 -> n=0, f=0x0001.
REQ-031 a=0x7BFF -> n=0x7FFF, ovf=1; a=0xF800 -> n=0x8000, ovf=0; a=0xFC00 -> n=0x8000, ovf=1; a=0x7E01 -> f=0x7E00, nan=1.
REQ-032 Feed 6 back-to-back operands while holding out_ready=0 for cycles 4-7 -> all 6 results delivered in order, outputs stable while stalled, in_ready=0 while stalled.
REQ-033 Assert rst with 2 operands in flight -> out_valid=0 immediately and no stale result after release; the next operand completes with latency 3.

Source files
------------

// File: rtl/half_exp2_split_pkg.sv
// ---------------------------------------------------------------------------
// half_exp2_split_pkg: half-precision field widths and constants for the split.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package half_exp2_split_pkg;

  localparam int HALF_W   = 16;
  localparam int EXP_W    = 5;
  localparam int MANT_W   = 10;
  localparam int BIAS     = 15;

  localparam logic [HALF_W-1:0] QNAN = 16'h7E00;
  localparam logic [HALF_W-1:0] NMAX = 16'h7FFF;
  localparam logic [HALF_W-1:0] NMIN = 16'h8000;
  localparam logic [EXP_W-1:0]  EXP_MAX = '1;

  // Unsigned magnitude in Q16.24 covers every finite half exactly.
  localparam int Q_INT_W  = 16;
  localparam int Q_FRAC_W = 24;
  localparam int Q_W      = Q_INT_W + Q_FRAC_W;
  localparam int LZ_W     = 5;

  typedef enum logic [1:0] {
    CLS_FIN = 2'd0,
    CLS_INF = 2'd1,
    CLS_NAN = 2'd2
  } cls_t;

endpackage

`default_nettype wire

// File: rtl/half_exp2_split_lzc24.sv
// ---------------------------------------------------------------------------
// lzc24: combinational leading-zero count of a 24-bit word (24 when zero).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lzc24
  import half_exp2_split_pkg::*;
(
  input  logic [Q_FRAC_W-1:0] d,
  output logic [LZ_W-1:0]     cnt
);

  // Ascending scan lets the most significant set bit win.
  always_comb begin
    cnt = LZ_W'(Q_FRAC_W);
    for (int i = 0; i < Q_FRAC_W; i++) begin
      if (d[i]) cnt = LZ_W'(Q_FRAC_W - 1 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/half_exp2_split.sv
// ---------------------------------------------------------------------------
// half_exp2_split: 3-stage split of half x into n=floor(x) and f=x-n (half).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module half_exp2_split
  import half_exp2_split_pkg::*;
#(
  parameter PRECISION = "HALF"
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HALF_W-1:0] a,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HALF_W-1:0] n,
  output logic [HALF_W-1:0] f,
  output logic              ovf,
  output logic              nan
);

  generate
    if (PRECISION != "HALF") begin : g_bad_precision
      $error("half_exp2_split: only PRECISION=\"HALF\" is supported");
    end
  endgenerate

  logic stall;
  logic adv;

  // S1 state
  logic             v1_q, v1_d;
  logic             s1_sign_q, s1_sign_d;
  cls_t             s1_cls_q, s1_cls_d;
  logic [Q_W-1:0]   s1_mag_q, s1_mag_d;
  // S2 state
  logic                v2_q, v2_d;
  logic [HALF_W-1:0]   s2_n_q, s2_n_d;
  logic                s2_ovf_q, s2_ovf_d;
  logic                s2_nan_q, s2_nan_d;
  logic [Q_FRAC_W-1:0] s2_fo_q, s2_fo_d;
  // S3 / output state
  logic              v3_q, v3_d;
  logic [HALF_W-1:0] n_q, n_d;
  logic [HALF_W-1:0] f_q, f_d;
  logic              ovf_q, ovf_d;
  logic              nan_q, nan_d;

  assign stall     = v3_q & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = ~stall;
  assign out_valid = v3_q;
  assign n         = n_q;
  assign f         = f_q;
  assign ovf       = ovf_q;
  assign nan       = nan_q;

  // ---------------- S1: unpack / classify ----------------
  logic [EXP_W-1:0]  a_exp;
  logic [MANT_W-1:0] a_mant;
  logic [5:0]        a_shamt;

  assign a_exp   = a[HALF_W-2 -: EXP_W];
  assign a_mant  = a[MANT_W-1:0];
  // Normal operand {1,mant} sits at weight 2^(exp-BIAS-MANT_W); in Q.24 that is a left shift by exp-1.
  assign a_shamt = 6'(a_exp) - 6'(BIAS + MANT_W - Q_FRAC_W);

  always_comb begin
    v1_d      = v1_q;
    s1_sign_d = s1_sign_q;
    s1_cls_d  = s1_cls_q;
    s1_mag_d  = s1_mag_q;
    if (adv) begin
      v1_d      = in_valid;
      s1_sign_d = a[HALF_W-1];
      if (a_exp == EXP_MAX) s1_cls_d = (a_mant != '0) ? CLS_NAN : CLS_INF;
      else                  s1_cls_d = CLS_FIN;
      if (a_exp == '0) s1_mag_d = Q_W'(a_mant);
      else             s1_mag_d = Q_W'({1'b1, a_mant}) << a_shamt;
    end
  end

  // ---------------- S2: fixed-point split / negate ----------------
  logic [Q_INT_W-1:0]  i_part;
  logic [Q_FRAC_W-1:0] f_part;
  logic [Q_INT_W:0]    i_up;

  assign i_part = s1_mag_q[Q_W-1:Q_FRAC_W];
  assign f_part = s1_mag_q[Q_FRAC_W-1:0];
  // Magnitude of floor(x) for negative x: I, or I+1 when a fraction remains.
  assign i_up   = {1'b0, i_part} + {{Q_INT_W{1'b0}}, |f_part};

  always_comb begin
    v2_d     = v2_q;
    s2_n_d   = s2_n_q;
    s2_ovf_d = s2_ovf_q;
    s2_nan_d = s2_nan_q;
    s2_fo_d  = s2_fo_q;
    if (adv) begin
      v2_d     = v1_q;
      s2_n_d   = i_part;
      s2_ovf_d = 1'b0;
      s2_nan_d = 1'b0;
      s2_fo_d  = f_part;
      case (s1_cls_q)
        CLS_NAN: begin
          s2_n_d   = '0;
          s2_fo_d  = '0;
          s2_nan_d = 1'b1;
        end
        CLS_INF: begin
          s2_n_d   = s1_sign_q ? NMIN : NMAX;
          s2_fo_d  = '0;
          s2_ovf_d = 1'b1;
        end
        default: begin
          if (s1_sign_q) begin
            s2_fo_d = -f_part;
            if (i_up > {1'b0, NMIN}) begin
              s2_n_d   = NMIN;
              s2_ovf_d = 1'b1;
            end else begin
              s2_n_d   = ~i_up[Q_INT_W-1:0] + 16'd1;
            end
          end else if (i_part[Q_INT_W-1]) begin
            s2_n_d   = NMAX;
            s2_ovf_d = 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- S3: normalize / pack ----------------
  logic [LZ_W-1:0]     lz;
  logic [Q_FRAC_W-1:0] fo_norm;
  logic [HALF_W-1:0]   f_pack;

  lzc24 u_lzc24 (
    .d   (s2_fo_q),
    .cnt (lz)
  );

  assign fo_norm = s2_fo_q << lz;

  // Leading one at p = 23-lz gives exponent p-9 = (BIAS-1)-lz; p<10 stays subnormal.
  always_comb begin
    f_pack = '0;
    if (s2_nan_q) begin
      f_pack = QNAN;
    end else if (s2_fo_q == '0) begin
      f_pack = '0;
    end else if (lz <= LZ_W'(BIAS - 2)) begin
      f_pack = {1'b0, EXP_W'(BIAS - 1) - lz, fo_norm[Q_FRAC_W-2 -: MANT_W]};
    end else begin
      f_pack = {{(HALF_W-MANT_W){1'b0}}, s2_fo_q[MANT_W-1:0]};
    end
  end

  always_comb begin
    v3_d  = v3_q;
    n_d   = n_q;
    f_d   = f_q;
    ovf_d = ovf_q;
    nan_d = nan_q;
    if (adv) begin
      v3_d  = v2_q;
      n_d   = s2_n_q;
      f_d   = f_pack;
      ovf_d = s2_ovf_q;
      nan_d = s2_nan_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_cls_q  <= CLS_FIN;
      s1_mag_q  <= '0;
      v2_q      <= 1'b0;
      s2_n_q    <= '0;
      s2_ovf_q  <= 1'b0;
      s2_nan_q  <= 1'b0;
      s2_fo_q   <= '0;
      v3_q      <= 1'b0;
      n_q       <= '0;
      f_q       <= '0;
      ovf_q     <= 1'b0;
      nan_q     <= 1'b0;
    end else begin
      v1_q      <= v1_d;
      s1_sign_q <= s1_sign_d;
      s1_cls_q  <= s1_cls_d;
      s1_mag_q  <= s1_mag_d;
      v2_q      <= v2_d;
      s2_n_q    <= s2_n_d;
      s2_ovf_q  <= s2_ovf_d;
      s2_nan_q  <= s2_nan_d;
      s2_fo_q   <= s2_fo_d;
      v3_q      <= v3_d;
      n_q       <= n_d;
      f_q       <= f_d;
      ovf_q     <= ovf_d;
      nan_q     <= nan_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_half_exp2_split.sv
// ---------------------------------------------------------------------------
// tb_half_exp2_split: directed vector table plus stall and reset sequences.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_half_exp2_split;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] n;
  logic [15:0] f;
  logic        ovf;
  logic        nan;

  always #5 clk = ~clk;

  half_exp2_split #(.PRECISION("HALF")) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .n         (n),
    .f         (f),
    .ovf       (ovf),
    .nan       (nan)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] n;
    logic [15:0] f;
    logic        ovf;
    logic        nan;
  } vec_t;

  localparam int NV = 21;
  vec_t tab [NV];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    nvec++;
    if (act !== exp_v) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input int idx);
    int lat;
    a         = tab[idx].a;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk($sformatf("v%0d(%h) latency", idx, tab[idx].a), 32'(lat), 32'd3);
    chk($sformatf("v%0d(%h) n", idx, tab[idx].a), 32'(n), 32'(tab[idx].n));
    chk($sformatf("v%0d(%h) f", idx, tab[idx].a), 32'(f), 32'(tab[idx].f));
    chk($sformatf("v%0d(%h) ovf", idx, tab[idx].a), 32'(ovf), 32'(tab[idx].ovf));
    chk($sformatf("v%0d(%h) nan", idx, tab[idx].a), 32'(nan), 32'(tab[idx].nan));
    step();
  endtask

  initial begin
    //            a         n         f         ovf   nan
    tab[0]  = '{16'h3E00, 16'h0001, 16'h3800, 1'b0, 1'b0}; // 1.5
    tab[1]  = '{16'hBE00, 16'hFFFE, 16'h3800, 1'b0, 1'b0}; // -1.5
    tab[2]  = '{16'hB400, 16'hFFFF, 16'h3A00, 1'b0, 1'b0}; // -0.25
    tab[3]  = '{16'h8001, 16'hFFFF, 16'h3BFF, 1'b0, 1'b0}; // -2^-24, truncated
    tab[4]  = '{16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b0}; // 2^-24
    tab[5]  = '{16'h7BFF, 16'h7FFF, 16'h0000, 1'b1, 1'b0}; // 65504
    tab[6]  = '{16'hF800, 16'h8000, 16'h0000, 1'b0, 1'b0}; // -32768 exactly
    tab[7]  = '{16'hFC00, 16'h8000, 16'h0000, 1'b1, 1'b0}; // -Inf
    tab[8]  = '{16'h7C00, 16'h7FFF, 16'h0000, 1'b1, 1'b0}; // +Inf
    tab[9]  = '{16'h7E01, 16'h0000, 16'h7E00, 1'b0, 1'b1}; // NaN
    tab[10] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0}; // +0
    tab[11] = '{16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b0}; // -0
    tab[12] = '{16'h3C00, 16'h0001, 16'h0000, 1'b0, 1'b0}; // 1.0
    tab[13] = '{16'h3555, 16'h0000, 16'h3555, 1'b0, 1'b0}; // ~0.333
    tab[14] = '{16'hC0A0, 16'hFFFD, 16'h3980, 1'b0, 1'b0}; // -2.3125 -> -3 + 0.6875
    tab[15] = '{16'h7800, 16'h7FFF, 16'h0000, 1'b1, 1'b0}; // 32768
    tab[16] = '{16'h77FF, 16'h7FF0, 16'h0000, 1'b0, 1'b0}; // 32752
    tab[17] = '{16'h03FF, 16'h0000, 16'h03FF, 1'b0, 1'b0}; // largest subnormal
    tab[18] = '{16'h0400, 16'h0000, 16'h0400, 1'b0, 1'b0}; // smallest normal
    tab[19] = '{16'hFBFF, 16'h8000, 16'h0000, 1'b1, 1'b0}; // -65504
    tab[20] = '{16'hFE00, 16'h0000, 16'h7E00, 1'b0, 1'b1}; // negative qNaN

    // Reset state
    repeat (2) step();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset n", 32'(n), 32'd0);
    chk("reset f", 32'(f), 32'd0);
    chk("reset ovf/nan", 32'({ovf, nan}), 32'd0);
    rst = 1'b0;
    step();

    // Single operands through an idle pipe
    for (int i = 0; i < NV; i++) run_one(i);

    // Six back-to-back operands, consumer stalls in cycles 4-7
    begin
      int sent, got, c;
      bit prev_stall, accepted;
      logic [33:0] snap;
      sent = 0; got = 0; c = 0; prev_stall = 1'b0; snap = '0;
      while (got < 6 && c < 60) begin
        c++;
        out_ready = !(c >= 4 && c <= 7);
        if (sent < 6) begin
          in_valid = 1'b1;
          a        = tab[sent].a;
        end else begin
          in_valid = 1'b0;
        end
        #1;
        if (out_valid && !out_ready) begin
          chk($sformatf("stall c%0d in_ready", c), 32'(in_ready), 32'd0);
          if (prev_stall)
            chk($sformatf("stall c%0d outputs held", c), 32'({n, f, ovf, nan}), 32'(snap));
          snap       = {n, f, ovf, nan};
          prev_stall = 1'b1;
        end else begin
          prev_stall = 1'b0;
        end
        if (out_valid && out_ready) begin
          chk($sformatf("burst r%0d n", got), 32'(n), 32'(tab[got].n));
          chk($sformatf("burst r%0d f", got), 32'(f), 32'(tab[got].f));
          chk($sformatf("burst r%0d ovf/nan", got), 32'({ovf, nan}), 32'({tab[got].ovf, tab[got].nan}));
          got++;
        end
        accepted = in_valid && in_ready;
        step();
        if (accepted) sent++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("burst results delivered", 32'(got), 32'd6);
      chk("burst operands accepted", 32'(sent), 32'd6);
    end
    step();

    // Reset with operands in flight, the oldest already at the output
    begin
      int stale;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
        a        = tab[k].a;
        in_valid = 1'b1;
        step();
      end
      in_valid = 1'b0;
      chk("pre-reset out_valid", 32'(out_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async reset out_valid", 32'(out_valid), 32'd0);
      chk("async reset in_ready", 32'(in_ready), 32'd1);
      chk("async reset n/f", 32'({n, f}), 32'd0);
      step();
      step();
      rst = 1'b0;
      stale = 0;
      repeat (6) begin
        step();
        if (out_valid) stale++;
      end
      chk("no stale result after reset", 32'(stale), 32'd0);
      run_one(14);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
